// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: raster timing for a VGA-style display. A clock divider produces a
// pixel-rate strobe (pixel_tick). On each pixel advance the column/line
// counters step through the full frame, including the blanking intervals.
// The syncs and the visible-area flag are decoded from the counter values.
//
// Ports:
//   clk          in   system clock; all state changes on its rising edge
//   rst_n        in   asynchronous active-low reset
//   Hcount[9:0]  out  current pixel column, 0 .. H_TOTAL-1
//   Vcount[9:0]  out  current line,         0 .. V_TOTAL-1
//   video_on     out  1 while (Hcount, Vcount) is inside the visible area
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   pixel_tick   out  one-clk strobe; the counters advance on the edge that
//                     ends a pixel_tick-high cycle
//   frame_start  out  one-clk pulse in the cycle the counters first show
//                     (0,0) after wrapping from the last pixel of a frame
//
// No handshakes: every output is a free-running registered status signal.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] Hcount,
    output logic [9:0] Vcount,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Divider values 0..15 cover the whole CLK_DIV range 1..16.
    localparam int                DIV_W    = 4;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HSYNC_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HSYNC_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VSYNC_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VSYNC_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        // Divider: 0..CLK_DIV-1, wrapping. With CLK_DIV=1 it stays at 0.
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

        // The strobe is registered, so it is high in exactly the cycle where
        // the divider holds its last value. Out of reset it is 0 even for
        // CLK_DIV=1, and becomes permanently 1 from the first edge on.
        tick_d = (div_d == DIV_LAST);

        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;

        // Counters move only on the edge that closes a tick-high cycle.
        if (tick_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        // Decode from the next counter values so the registered flags line
        // up with the registered counters with no skew.
        video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
        hsync_d    = !((hcount_d >= HSYNC_BEG) && (hcount_d < HSYNC_END));
        vsync_d    = !((vcount_d >= VSYNC_BEG) && (vcount_d < VSYNC_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            tick_q        <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            // (0,0) is a visible pixel outside both sync windows.
            video_on_q    <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            tick_q        <= tick_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Hcount      = hcount_q;
    assign Vcount      = vcount_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_tick  = tick_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock and reset:
//   u_def : default 640x480 timing, CLK_DIV=4
//   u_s1  : tiny 15x8 raster, CLK_DIV=1
//   u_s3  : tiny 18x11 raster, CLK_DIV=3
// Expected values come from a closed-form model of the number of rising
// edges k since reset release, plus hand-computed directed constants.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Small-raster parameters
    localparam int S1_HV = 8,  S1_HF = 2, S1_HS = 3, S1_HB = 2;
    localparam int S1_VV = 4,  S1_VF = 1, S1_VS = 2, S1_VB = 1;
    localparam int S3_HV = 10, S3_HF = 2, S3_HS = 3, S3_HB = 3;
    localparam int S3_VV = 6,  S3_VF = 1, S3_VS = 2, S3_VB = 2;

    logic clk;
    logic rst_n;

    logic [9:0] d_h, d_v, s1_h, s1_v, s3_h, s3_v;
    logic d_vo, d_hs, d_vs, d_pt, d_fs;
    logic s1_vo, s1_hs, s1_vs, s1_pt, s1_fs;
    logic s3_vo, s3_hs, s3_vs, s3_pt, s3_fs;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;   // rising edges since reset release

    int d_hs_low, d_vo_low, s1_tick_hi, s1_fs_cnt, s3_fs_cnt;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .Hcount(d_h), .Vcount(d_v),
        .video_on(d_vo), .hsync(d_hs), .vsync(d_vs),
        .pixel_tick(d_pt), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(S1_HV), .H_FP(S1_HF), .H_SYNC(S1_HS), .H_BP(S1_HB),
        .V_VISIBLE(S1_VV), .V_FP(S1_VF), .V_SYNC(S1_VS), .V_BP(S1_VB)
    ) u_s1 (
        .clk(clk), .rst_n(rst_n), .Hcount(s1_h), .Vcount(s1_v),
        .video_on(s1_vo), .hsync(s1_hs), .vsync(s1_vs),
        .pixel_tick(s1_pt), .frame_start(s1_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(3),
        .H_VISIBLE(S3_HV), .H_FP(S3_HF), .H_SYNC(S3_HS), .H_BP(S3_HB),
        .V_VISIBLE(S3_VV), .V_FP(S3_VF), .V_SYNC(S3_VS), .V_BP(S3_VB)
    ) u_s3 (
        .clk(clk), .rst_n(rst_n), .Hcount(s3_h), .Vcount(s3_v),
        .video_on(s3_vo), .hsync(s3_hs), .vsync(s3_vs),
        .pixel_tick(s3_pt), .frame_start(s3_fs)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_assert++;
        assert (got === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Pixel advances completed after kk edges. The strobe is high after
    // edge m when m>=1 and m%d==d-1; the advance lands on edge m+1.
    function automatic int adv_cnt(input int kk, input int d);
        if (kk <= 0) return 0;
        if (d == 1)  return kk - 1;
        return kk / d;
    endfunction

    task automatic check_inst(
        input string nm, input int d,
        input int hv, input int hf, input int hs, input int hb,
        input int vv, input int vf, input int vs, input int vb,
        input logic [9:0] hc, input logic [9:0] vc,
        input logic vo, input logic hsy, input logic vsy,
        input logic pt, input logic fs
    );
        int ht, vt, p, eh, ev, e_tick, e_fs;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        p  = adv_cnt(k, d);
        eh = p % ht;
        ev = (p / ht) % vt;
        e_tick = (k >= 1 && (k % d) == d - 1) ? 1 : 0;
        e_fs   = (k >= 1 && p != adv_cnt(k - 1, d) && (p % (ht * vt)) == 0) ? 1 : 0;
        chk({nm, "_hrange"}, 32'(hc < 10'(ht)), 1);
        chk({nm, "_vrange"}, 32'(vc < 10'(vt)), 1);
        chk({nm, "_hcount"}, 32'(hc), eh);
        chk({nm, "_vcount"}, 32'(vc), ev);
        chk({nm, "_video_on"}, 32'(vo), (eh < hv && ev < vv) ? 1 : 0);
        chk({nm, "_hsync"}, 32'(hsy), (eh >= hv + hf && eh < hv + hf + hs) ? 0 : 1);
        chk({nm, "_vsync"}, 32'(vsy), (ev >= vv + vf && ev < vv + vf + vs) ? 0 : 1);
        chk({nm, "_pixel_tick"}, 32'(pt), e_tick);
        chk({nm, "_frame_start"}, 32'(fs), e_fs);
    endtask

    task automatic check_all();
        check_inst("def", 4, 640, 16, 96, 48, 480, 10, 2, 33,
                   d_h, d_v, d_vo, d_hs, d_vs, d_pt, d_fs);
        check_inst("s1", 1, S1_HV, S1_HF, S1_HS, S1_HB, S1_VV, S1_VF, S1_VS, S1_VB,
                   s1_h, s1_v, s1_vo, s1_hs, s1_vs, s1_pt, s1_fs);
        check_inst("s3", 3, S3_HV, S3_HF, S3_HS, S3_HB, S3_VV, S3_VF, S3_VS, S3_VB,
                   s3_h, s3_v, s3_vo, s3_hs, s3_vs, s3_pt, s3_fs);
    endtask

    // Advance n edges; sample on the falling edge after each.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_all();
            if (!d_hs)  d_hs_low++;
            if (!d_vo)  d_vo_low++;
            if (s1_pt)  s1_tick_hi++;
            if (s1_fs)  s1_fs_cnt++;
            if (s3_fs)  s3_fs_cnt++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_def_h"},  32'(d_h), 0);
        chk({tag, "_def_v"},  32'(d_v), 0);
        chk({tag, "_def_vo"}, 32'(d_vo), 1);
        chk({tag, "_def_hs"}, 32'(d_hs), 1);
        chk({tag, "_def_vs"}, 32'(d_vs), 1);
        chk({tag, "_def_pt"}, 32'(d_pt), 0);
        chk({tag, "_def_fs"}, 32'(d_fs), 0);
        chk({tag, "_s1_pt"},  32'(s1_pt), 0);
        chk({tag, "_s3_h"},   32'(s3_h), 0);
        chk({tag, "_s3_v"},   32'(s3_v), 0);
        chk({tag, "_s3_vo"},  32'(s3_vo), 1);
        chk({tag, "_s3_hs"},  32'(s3_hs), 1);
        chk({tag, "_s3_vs"},  32'(s3_vs), 1);
        chk({tag, "_s3_fs"},  32'(s3_fs), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        k     = 0;
        d_hs_low = 0; d_vo_low = 0; s1_tick_hi = 0; s1_fs_cnt = 0; s3_fs_cnt = 0;

        // Reset state, checked while reset is held across clock edges.
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        check_all();

        // Release away from the active edge.
        rst_n = 1'b1;

        // Divide-by-4: strobe in the 4th clk only, first advance at edge 4.
        step(3);
        chk("r1_tick_edge3", 32'(d_pt), 1);
        chk("r1_h_edge3", 32'(d_h), 0);
        step(1);
        chk("r1_tick_edge4", 32'(d_pt), 0);
        chk("r1_h_edge4", 32'(d_h), 1);
        chk("r1_v_edge4", 32'(d_v), 0);

        // One full default line: 800 pixels x 4 clks.
        step(3195);
        chk("line_h_799", 32'(d_h), 799);
        chk("line_v_0", 32'(d_v), 0);
        step(1);
        chk("line_h_wrap", 32'(d_h), 0);
        chk("line_v_1", 32'(d_v), 1);
        chk("line_hsync_low_clks", 32'(d_hs_low), 384);
        chk("line_video_off_clks", 32'(d_vo_low), 640);
        // Tiny rasters across those 3200 edges: CLK_DIV=1 strobe always high;
        // s1 frame = 120 clks (first starts at edge 121), s3 frame = 594 clks.
        chk("s1_tick_always_hi", 32'(s1_tick_hi), 3200);
        chk("s1_frame_pulses", 32'(s1_fs_cnt), 26);
        chk("s3_frame_pulses", 32'(s3_fs_cnt), 5);

        // Fresh reset, then walk s3 into both sync windows (H=13, V=8).
        rst_n = 1'b0;
        k = 0;
        #1;
        check_reset_values("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        step(472);
        chk("s3_pre_h", 32'(s3_h), 13);
        chk("s3_pre_v", 32'(s3_v), 8);
        chk("s3_pre_hsync", 32'(s3_hs), 0);
        chk("s3_pre_vsync", 32'(s3_vs), 0);

        // Mid-sync asynchronous reset: outputs must clear before any edge.
        #2;
        rst_n = 1'b0;
        k = 0;
        #1;
        check_reset_values("rst_mid");
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // The post-reset sequence repeats exactly.
        step(3);
        chk("r2_tick_edge3", 32'(d_pt), 1);
        chk("r2_h_edge3", 32'(d_h), 0);
        step(1);
        chk("r2_tick_edge4", 32'(d_pt), 0);
        chk("r2_h_edge4", 32'(d_h), 1);
        chk("r2_s3_h_edge4", 32'(s3_h), 1);

        // Run across two more s3 frame boundaries (edges 594 and 1188).
        s3_fs_cnt = 0;
        step(1300);
        chk("s3_frame_pulses_2", 32'(s3_fs_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
REQ-002 Parameter H_VISIBLE/H_FP/H_SYNC/H_BP, default 640/16/96/48, meaning horizontal pixel counts.
REQ-003 Parameter V_VISIBLE/V_FP/V_SYNC/V_BP, default 480/10/2/33, meaning vertical line counts.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 Hcount  output  10  current pixel column, 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800).
REQ-007 Vcount  output  10  current line, 0..V_TOTAL-1 (V_TOTAL = sum of V params = 525).
REQ-008 video_on  output  1  high when current pixel is in the visible area.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 pixel_tick  output  1  one-clk pulse marking each pixel-rate advance.
REQ-012 frame_start  output  1  one-clk pulse when counters enter (0,0) from wrap.

Function
REQ-013 Divider counter counts 0..CLK_DIV-1 and wraps; pixel_tick high for exactly the one clk in which the divider equals CLK_DIV-1.
REQ-014 CLK_DIV=1: pixel_tick permanently high after reset; counters advance every clk.
REQ-015 Hcount and Vcount change only on the clk edge that ends a pixel_tick-high cycle; otherwise they hold.
REQ-016 Hcount increments by 1 per advance; at H_TOTAL-1 it wraps to 0 on the next advance.
REQ-017 Vcount increments by 1 only on the advance where Hcount wraps; at V_TOTAL-1 with Hcount wrap, Vcount wraps to 0.
REQ-018 No counter ever holds a value >= its TOTAL; out-of-range cannot occur, even on the first advance after reset.
REQ-019 video_on, hsync, vsync are registered outputs, decoded from the next counter values so they are valid in the same cycle as the Hcount/Vcount they describe (zero relative skew).
REQ-020 video_on = (Hcount < H_VISIBLE) and (Vcount < V_VISIBLE).
REQ-021 hsync low iff H_VISIBLE+H_FP <= Hcount < H_VISIBLE+H_FP+H_SYNC (656..751 default).
REQ-022 vsync low iff V_VISIBLE+V_FP <= Vcount < V_VISIBLE+V_FP+V_SYNC (490..491 default).
REQ-023 frame_start high for one clk, the cycle in which the counters first show (0,0) after a (H_TOTAL-1, V_TOTAL-1) wrap; not asserted on exit from reset.
REQ-024 Downstream screen renderers register RGB on clk from Hcount/Vcount; this block guarantees the counters are stable for CLK_DIV clks per pixel.

Reset
REQ-025 While rst_n low (asynchronously on its falling edge): divider=0, Hcount=0, Vcount=0, video_on=1, hsync=1, vsync=1, pixel_tick=0, frame_start=0.
REQ-026 First pixel_tick after rst_n deasserts occurs on the CLK_DIV-th clk edge (divider counts 0..CLK_DIV-1 first).
REQ-027 Reset asserted mid-frame or mid-sync: all outputs return to REQ-025 values immediately, no partial pulses after release.

Verification
REQ-028 Release reset, CLK_DIV=4, run 4 clks -> pixel_tick high only in 4th clk; Hcount goes 0->1 at that edge; Vcount=0.
REQ-029 Run one full line -> Hcount goes 799->0, Vcount 0->1; hsync low for exactly 96*4=384 clks starting Hcount=656; video_on low from Hcount=640.
REQ-030 Run one full frame -> 800*525*4=1,680,000 clks per frame; vsync low exactly on Vcount 490 and 491 (2*800*4 clks); frame_start single one-clk pulse at (0,0).
REQ-031 Assert rst_n low at Hcount=700, Vcount=491 (hsync and vsync both low) -> same instant Hcount=0, Vcount=0, hsync=1, vsync=1, video_on=1; after release REQ-028 sequence repeats.
REQ-032 CLK_DIV=1 -> pixel_tick constant 1, Hcount increments every clk, line period 800 clks, frame period 420,000 clks.
REQ-033 Every clk assert: Hcount<800, Vcount<525, video_on/hsync/vsync equal REQ-020..022 decode of current counters.
